// File: rtl/ysyx22041405_wbu_pkg.sv
// Shared types and constants for the write-back unit: FSM encoding,
// load funct3 codes and payload field widths.
package ysyx22041405_wbu_pkg;

  localparam int WBU_WIDTH = 32;
  localparam int RF_ADDR_W = 5;
  localparam int LD_FMT_W  = 3;
  localparam int INSTRET_W = 64;

  localparam logic [LD_FMT_W-1:0] LD_LB  = 3'b000;
  localparam logic [LD_FMT_W-1:0] LD_LH  = 3'b001;
  localparam logic [LD_FMT_W-1:0] LD_LW  = 3'b010;
  localparam logic [LD_FMT_W-1:0] LD_LBU = 3'b100;
  localparam logic [LD_FMT_W-1:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2,
    S_HALT     = 2'd3
  } wbu_state_e;

endpackage

// File: rtl/ysyx22041405_load_ext.sv
// Picks the byte/half lane addressed by the load and sign/zero-extends it.
module ysyx22041405_load_ext
  import ysyx22041405_wbu_pkg::*;
#(
  parameter int WIDTH = WBU_WIDTH
) (
  input  logic [WIDTH-1:0]    i_word,
  input  logic [1:0]          i_addr,
  input  logic [LD_FMT_W-1:0] i_fmt,
  output logic [WIDTH-1:0]    o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr, 3'b000} +: 8];
  assign w_half = i_word[{i_addr[1], 4'b0000} +: 16];

  always_comb begin
    o_data = '0;
    case (i_fmt)
      LD_LB:   o_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      LD_LH:   o_data = {{(WIDTH-16){w_half[15]}}, w_half};
      LD_LW:   o_data = i_word;
      LD_LBU:  o_data = {{(WIDTH-8){1'b0}}, w_byte};
      LD_LHU:  o_data = {{(WIDTH-16){1'b0}}, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx22041405_wbu.sv
// Write-back unit: takes one instruction from the LSU, waits for load data
// when needed, writes the register file and retires the instruction.
module ysyx22041405_wbu
  import ysyx22041405_wbu_pkg::*;
#(
  parameter int WIDTH = WBU_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_valid,
  output logic                  wb_ready,
  input  logic                  ls_rf_we,
  input  logic [RF_ADDR_W-1:0]  ls_rf_waddr,
  input  logic [WIDTH-1:0]      ls_alu_result,
  input  logic [WIDTH-1:0]      ls_pc,
  input  logic [WIDTH-1:0]      ls_inst,
  input  logic                  ls_load,
  input  logic [LD_FMT_W-1:0]   ls_load_fmt,
  input  logic                  ls_ebreak,
  input  logic                  ls_inst_valid,
  input  logic                  dm_rvalid,
  input  logic [WIDTH-1:0]      dm_rdata,
  output logic                  wb_rf_we,
  output logic [RF_ADDR_W-1:0]  wb_rf_waddr,
  output logic [WIDTH-1:0]      wb_rf_wdata,
  output logic                  commit_valid,
  output logic [WIDTH-1:0]      commit_pc,
  output logic [WIDTH-1:0]      commit_inst,
  output logic                  halt,
  output logic                  halt_trap,
  output logic [INSTRET_W-1:0]  instret
);

  wbu_state_e r_state, w_next;

  logic                 r_rf_we, r_load, r_ebreak, r_inst_valid;
  logic [RF_ADDR_W-1:0] r_waddr;
  logic [LD_FMT_W-1:0]  r_fmt;
  logic [WIDTH-1:0]     r_alu, r_pc, r_inst, r_rdata;
  logic [INSTRET_W-1:0] r_instret;
  logic [WIDTH-1:0]     w_load_data;
  logic                 w_accept, w_stop;

  // An ebreak or illegal instruction sitting in COMMIT blocks further intake.
  assign w_stop   = r_ebreak || !r_inst_valid;
  assign wb_ready = rst && ((r_state == S_IDLE) || ((r_state == S_COMMIT) && !w_stop));
  assign w_accept = ls_valid && wb_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = ls_load ? S_WAIT_MEM : S_COMMIT;
        else          w_next = S_IDLE;
      end
      S_WAIT_MEM: begin
        if (dm_rvalid) w_next = S_COMMIT;
        else           w_next = S_WAIT_MEM;
      end
      S_COMMIT: begin
        if (w_stop)        w_next = S_HALT;
        else if (w_accept) w_next = ls_load ? S_WAIT_MEM : S_COMMIT;
        else               w_next = S_IDLE;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_COMMIT) r_instret <= r_instret + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rf_we      <= 1'b0;
      r_waddr      <= '0;
      r_alu        <= '0;
      r_pc         <= '0;
      r_inst       <= '0;
      r_load       <= 1'b0;
      r_fmt        <= '0;
      r_ebreak     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_accept) begin
        r_rf_we      <= ls_rf_we;
        r_waddr      <= ls_rf_waddr;
        r_alu        <= ls_alu_result;
        r_pc         <= ls_pc;
        r_inst       <= ls_inst;
        r_load       <= ls_load;
        r_fmt        <= ls_load_fmt;
        r_ebreak     <= ls_ebreak;
        r_inst_valid <= ls_inst_valid;
      end
      if ((r_state == S_WAIT_MEM) && dm_rvalid) r_rdata <= dm_rdata;
    end
  end

  ysyx22041405_load_ext #(.WIDTH(WIDTH)) u_load_ext (
    .i_word (r_rdata),
    .i_addr (r_alu[1:0]),
    .i_fmt  (r_fmt),
    .o_data (w_load_data)
  );

  assign commit_valid = (r_state == S_COMMIT);
  assign wb_rf_we     = commit_valid && r_rf_we && (r_waddr != 5'd0);
  assign wb_rf_waddr  = r_waddr;
  assign wb_rf_wdata  = r_load ? w_load_data : r_alu;
  assign commit_pc    = r_pc;
  assign commit_inst  = r_inst;
  assign halt         = (r_state == S_HALT);
  assign halt_trap    = halt && !r_inst_valid;
  assign instret      = r_instret;

endmodule

// File: tb/tb_ysyx22041405_wbu.sv
// Directed bench for the write-back unit with hand-computed expectations.
module tb_ysyx22041405_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, wb_ready, ls_rf_we, ls_load, ls_ebreak, ls_inst_valid;
  logic [4:0]  ls_rf_waddr, wb_rf_waddr;
  logic [2:0]  ls_load_fmt;
  logic [31:0] ls_alu_result, ls_pc, ls_inst, dm_rdata, wb_rf_wdata, commit_pc, commit_inst;
  logic        dm_rvalid, wb_rf_we, commit_valid, halt, halt_trap;
  logic [63:0] instret;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  ysyx22041405_wbu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .wb_ready(wb_ready),
    .ls_rf_we(ls_rf_we), .ls_rf_waddr(ls_rf_waddr), .ls_alu_result(ls_alu_result),
    .ls_pc(ls_pc), .ls_inst(ls_inst), .ls_load(ls_load), .ls_load_fmt(ls_load_fmt),
    .ls_ebreak(ls_ebreak), .ls_inst_valid(ls_inst_valid), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .halt(halt), .halt_trap(halt_trap), .instret(instret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ls_valid = 1'b0;
  endtask

  task automatic send(input logic ld, input logic [2:0] fmt, input logic we,
                      input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] pc,
                      input logic ebr, input logic iv);
    ls_valid = 1'b1; ls_load = ld; ls_load_fmt = fmt; ls_rf_we = we; ls_rf_waddr = wa;
    ls_alu_result = alu; ls_pc = pc; ls_inst = pc ^ 32'h0000_0013;
    ls_ebreak = ebr; ls_inst_valid = iv;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_in();
    tick();
    rst = 1'b1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] fmt, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    send(1'b1, fmt, 1'b1, 5'd9, addr, 32'h8000_0100, 1'b0, 1'b1);
    tick();
    idle_in();
    dm_rvalid = 1'b1; dm_rdata = rdata;
    tick();
    dm_rvalid = 1'b0;
    chk({tag, "_cv"}, {63'd0, commit_valid}, 64'd1);
    chk({tag, "_wdata"}, {32'd0, wb_rf_wdata}, {32'd0, exp});
    tick();
  endtask

  initial begin
    rst = 1'b0; ls_valid = 1'b0; ls_rf_we = 1'b0; ls_rf_waddr = 5'd0; ls_alu_result = 32'd0;
    ls_pc = 32'd0; ls_inst = 32'd0; ls_load = 1'b0; ls_load_fmt = 3'd0; ls_ebreak = 1'b0;
    ls_inst_valid = 1'b1; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    tick(); tick();
    chk("rst_ready", {63'd0, wb_ready}, 64'd0);
    chk("rst_cv", {63'd0, commit_valid}, 64'd0);
    chk("rst_we", {63'd0, wb_rf_we}, 64'd0);
    chk("rst_halt", {63'd0, halt}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    // ls_valid while in reset must not be taken
    send(1'b0, 3'd0, 1'b1, 5'd5, 32'h10, 32'h8000_0000, 1'b0, 1'b1);
    tick();
    chk("rst_ignore_cv", {63'd0, commit_valid}, 64'd0);
    chk("rst_ignore_ready", {63'd0, wb_ready}, 64'd0);
    idle_in(); rst = 1'b1; #1;
    chk("idle_ready", {63'd0, wb_ready}, 64'd1);

    // addi x5
    send(1'b0, 3'd0, 1'b1, 5'd5, 32'h0000_0010, 32'h8000_0000, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("addi_cv", {63'd0, commit_valid}, 64'd1);
    chk("addi_we", {63'd0, wb_rf_we}, 64'd1);
    chk("addi_waddr", {59'd0, wb_rf_waddr}, 64'd5);
    chk("addi_wdata", {32'd0, wb_rf_wdata}, 64'h10);
    chk("addi_pc", {32'd0, commit_pc}, 64'h8000_0000);
    chk("addi_inst", {32'd0, commit_inst}, 64'h8000_0013);
    tick();
    chk("addi_cv_drop", {63'd0, commit_valid}, 64'd0);
    chk("addi_we_drop", {63'd0, wb_rf_we}, 64'd0);
    chk("addi_instret", instret, 64'd1);

    // stray dm_rvalid in IDLE
    dm_rvalid = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    tick();
    dm_rvalid = 1'b0;
    chk("stray_rvalid_cv", {63'd0, commit_valid}, 64'd0);

    // LB from 0x8000_0003, data three cycles after accept
    send(1'b1, 3'b000, 1'b1, 5'd7, 32'h8000_0003, 32'h8000_0004, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("lb_wait_ready", {63'd0, wb_ready}, 64'd0);
    send(1'b0, 3'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h8000_0008, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("lb_wait_ready2", {63'd0, wb_ready}, 64'd0);
    chk("lb_wait_cv", {63'd0, commit_valid}, 64'd0);
    dm_rvalid = 1'b1; dm_rdata = 32'h80FF_1234;
    tick();
    dm_rvalid = 1'b0;
    chk("lb_cv", {63'd0, commit_valid}, 64'd1);
    chk("lb_wdata", {32'd0, wb_rf_wdata}, 64'hFFFF_FF80);
    chk("lb_waddr", {59'd0, wb_rf_waddr}, 64'd7);
    chk("lb_pc", {32'd0, commit_pc}, 64'h8000_0004);
    tick();
    chk("lb_instret", instret, 64'd2);

    do_load("lhu", 3'b101, 32'h8000_0012, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("fmt011", 3'b011, 32'h8000_0010, 32'h1234_5678, 32'h0000_0000);
    do_load("lh", 3'b001, 32'h8000_0012, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lw", 3'b010, 32'h8000_0011, 32'h1234_5678, 32'h1234_5678);
    do_load("lbu", 3'b100, 32'h8000_0011, 32'h0000_AB00, 32'h0000_00AB);
    do_load("lb_pos", 3'b000, 32'h8000_0010, 32'h0000_007F, 32'h0000_007F);

    // write to x0
    send(1'b0, 3'd0, 1'b1, 5'd0, 32'h55, 32'h8000_0020, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("x0_cv", {63'd0, commit_valid}, 64'd1);
    chk("x0_we", {63'd0, wb_rf_we}, 64'd0);
    tick();

    // four back-to-back non-loads from a clean counter
    do_reset();
    chk("b2b_instret0", instret, 64'd0);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 3'd0, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h8000_0040 + 32'(4 * i), 1'b0, 1'b1);
      tick();
      chk("b2b_cv", {63'd0, commit_valid}, 64'd1);
      chk("b2b_wdata", {32'd0, wb_rf_wdata}, 64'h100 + 64'(i));
      chk("b2b_ready", {63'd0, wb_ready}, 64'd1);
    end
    idle_in();
    tick();
    chk("b2b_cv_end", {63'd0, commit_valid}, 64'd0);
    chk("b2b_instret", instret, 64'd4);

    // ebreak halts cleanly
    send(1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 32'h8000_0080, 1'b1, 1'b1);
    tick();
    idle_in();
    chk("ebreak_cv", {63'd0, commit_valid}, 64'd1);
    chk("ebreak_ready", {63'd0, wb_ready}, 64'd0);
    chk("ebreak_halt_early", {63'd0, halt}, 64'd0);
    tick();
    chk("ebreak_halt", {63'd0, halt}, 64'd1);
    chk("ebreak_trap", {63'd0, halt_trap}, 64'd0);
    chk("ebreak_ready_h", {63'd0, wb_ready}, 64'd0);
    send(1'b0, 3'd0, 1'b1, 5'd4, 32'h77, 32'h8000_0084, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("halt_stuck", {63'd0, halt}, 64'd1);
    chk("halt_cv", {63'd0, commit_valid}, 64'd0);
    chk("halt_instret", instret, 64'd5);

    // illegal instruction traps
    do_reset();
    send(1'b0, 3'd0, 1'b1, 5'd6, 32'h99, 32'h8000_00C0, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("illegal_cv", {63'd0, commit_valid}, 64'd1);
    chk("illegal_ready", {63'd0, wb_ready}, 64'd0);
    tick();
    chk("illegal_halt", {63'd0, halt}, 64'd1);
    chk("illegal_trap", {63'd0, halt_trap}, 64'd1);

    // reset while a load waits for memory
    do_reset();
    send(1'b1, 3'b010, 1'b1, 5'd8, 32'h8000_0100, 32'h8000_0104, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("rw_wait_ready", {63'd0, wb_ready}, 64'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
    tick();
    dm_rvalid = 1'b0;
    chk("rw_cv", {63'd0, commit_valid}, 64'd0);
    chk("rw_ready", {63'd0, wb_ready}, 64'd1);
    chk("rw_instret", instret, 64'd0);
    chk("rw_pc_zero", {32'd0, commit_pc}, 64'd0);
    chk("rw_halt", {63'd0, halt}, 64'd0);
    tick();
    chk("rw_cv2", {63'd0, commit_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
